// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port seen by the arbiter.
// master = the arbiter itself, slave = the clients and memory around it.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic                m_we;
  logic [DATA_W/8-1:0] m_be;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_gnt;
  logic                m_rvalid;
  logic [DATA_W-1:0]   m_rdata;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );

endinterface

// File: rtl/mem_arb_sat_counter.sv
// Saturating event counter with asynchronous clear; used for arbiter statistics.
module mem_arb_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so no path through always_comb leaves count_d unassigned (no latch).
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: flops use <= so every register samples its _d value at the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I, read-only) and load/store (D) with one transaction in flight.
// Optional MEM_ARB_STATS_EN adds saturating grant/stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int CNT_W        = 32
`endif
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.master bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  logic                  i_grant, d_grant;
  logic                  i_resp, d_resp;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_be;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Owner is chosen once in IDLE and stays locked until the response returns.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_d = (bus.i_req && (!bus.d_req || (streak_q == STREAK_MAX))) ? OWN_I : OWN_D;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.m_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // D-grant streak only matters while fetch is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (!bus.i_req) begin
      streak_d = '0;
    end else if (d_grant) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end else if (i_grant) begin
      streak_d = '0;
    end
  end

  always_comb begin
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    if (state_q == REQ) begin
      case (owner_q)
        OWN_I: begin
          req_addr = bus.i_addr;
          i_grant  = bus.m_gnt;
        end
        OWN_D: begin
          req_we    = bus.d_we;
          req_be    = bus.d_be;
          req_addr  = bus.d_addr;
          req_wdata = bus.d_wdata;
          d_grant   = bus.m_gnt;
        end
        default: ;
      endcase
    end
    if ((state_q == WAIT) && bus.m_rvalid) begin
      i_resp = (owner_q == OWN_I);
      d_resp = (owner_q == OWN_D);
    end
  end

  assign bus.m_req    = (state_q == REQ);
  assign bus.m_we     = req_we;
  assign bus.m_be     = req_be;
  assign bus.m_addr   = req_addr;
  assign bus.m_wdata  = req_wdata;

  assign bus.i_gnt    = i_grant;
  assign bus.i_rvalid = i_resp;
  assign bus.i_rdata  = i_resp ? bus.m_rdata : '0;
  assign bus.d_gnt    = d_grant;
  assign bus.d_rvalid = d_resp;
  assign bus.d_rdata  = d_resp ? bus.m_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic stall;
  assign stall = (state_q == REQ) && !bus.m_gnt;

  mem_arb_sat_counter #(.W(CNT_W)) u_i_grant_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (i_grant),
    .count (i_grant_cnt)
  );

  mem_arb_sat_counter #(.W(CNT_W)) u_d_grant_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (d_grant),
    .count (d_grant_cnt)
  );

  mem_arb_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );
`endif

  a_gnt_exclusive : assert property (@(posedge clock) disable iff (!reset)
    !(bus.i_gnt && bus.d_gnt));
  a_rvalid_exclusive : assert property (@(posedge clock) disable iff (!reset)
    !(bus.i_rvalid && bus.d_rvalid));
  a_gnt_needs_mem : assert property (@(posedge clock) disable iff (!reset)
    (bus.i_gnt || bus.d_gnt) |-> (bus.m_req && bus.m_gnt));

endmodule
